// File: rtl/mem_pkg.sv
// Shared constants and helpers for the memory building blocks.
package mem_pkg;

    localparam string MODE_STD  = "STD";
    localparam string MODE_FWFT = "FWFT";

    // Occupancy counters need one extra bit to represent a completely full store.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/sdp_distributed_ram_m.sv
// Simple dual-port LUT RAM: one synchronous write port, one async (or optionally registered) read port.
module sdp_distributed_ram_m #(
    parameter int    WORD_WIDTH     = 8,
    parameter int    ADDR_WIDTH     = 3,
    parameter string OUT_REGISTERED = "NO"
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WORD_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Contents are deliberately never reset so the array maps onto LUT RAM.
    logic [WORD_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    if (OUT_REGISTERED == "YES") begin : g_reg
        logic [WORD_WIDTH-1:0] rdata_q;
        always_ff @(posedge clk) rdata_q <= mem[raddr];
        assign rdata = rdata_q;
    end else begin : g_async
        assign rdata = mem[raddr];
    end

endmodule

// File: rtl/distributed_fifo_m.sv
// Single-clock FIFO on distributed RAM with STD (registered) or FWFT output and registered status flags.
module distributed_fifo_m
    import mem_pkg::*;
#(
    parameter int    WORD_WIDTH       = 8,
    parameter int    ADDR_WIDTH       = 3,
    parameter string MODE             = "STD",
    parameter int    ALMOST_FULL_THR  = 2 ** ADDR_WIDTH - 1,
    parameter int    ALMOST_EMPTY_THR = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [WORD_WIDTH-1:0]            wr_data,
    output logic                             full,
    output logic                             almost_full,
    output logic                             overflow,
    input  logic                             rd_en,
    output logic [WORD_WIDTH-1:0]            rd_data,
    output logic                             empty,
    output logic                             almost_empty,
    output logic                             underflow,
    output logic [cnt_width(ADDR_WIDTH)-1:0] count
);

    localparam int              DEPTH = 2 ** ADDR_WIDTH;
    localparam int              CW    = cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   AF_C    = CW'(ALMOST_FULL_THR);
    localparam logic [CW-1:0]   AE_C    = CW'(ALMOST_EMPTY_THR);

    if (ALMOST_FULL_THR < 0 || ALMOST_FULL_THR > DEPTH) begin : g_bad_af
        $error("distributed_fifo_m: ALMOST_FULL_THR out of range 0..DEPTH");
    end
    if (ALMOST_EMPTY_THR < 0 || ALMOST_EMPTY_THR > DEPTH) begin : g_bad_ae
        $error("distributed_fifo_m: ALMOST_EMPTY_THR out of range 0..DEPTH");
    end
    if (MODE != MODE_STD && MODE != MODE_FWFT) begin : g_bad_mode
        $error("distributed_fifo_m: MODE must be STD or FWFT");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [WORD_WIDTH-1:0] ram_rdata;
    logic                  wr_acc, rd_acc;

    // Accepts look only at the pre-edge flags, so full+rd+wr drops the write
    // and empty+rd+wr drops the read.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow  <= wr_en & full;
            underflow <= rd_en & empty;
        end
    end

    sdp_distributed_ram_m #(
        .WORD_WIDTH     (WORD_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .OUT_REGISTERED ("NO")
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    if (MODE == MODE_FWFT) begin : g_fwft
        assign rd_data = ram_rdata;
    end else begin : g_std
        // Output register sits here rather than in the RAM because it is
        // gated by read accept and cleared by reset.
        logic [WORD_WIDTH-1:0] rd_q;
        always_ff @(posedge clk) begin
            if (!rst_n)      rd_q <= '0;
            else if (rd_acc) rd_q <= ram_rdata;
        end
        assign rd_data = rd_q;
    end

endmodule

// File: tb/tb_distributed_fifo_m.sv
// Directed bench: an STD and a FWFT instance share one stimulus stream; each scenario checks inline.
module tb_distributed_fifo_m;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en, rd_en;
    logic [7:0] wr_data;

    logic       full_s, af_s, ovf_s, empty_s, ae_s, unf_s;
    logic [7:0] rd_data_s;
    logic [3:0] count_s;
    logic       full_f, af_f, ovf_f, empty_f, ae_f, unf_f;
    logic [7:0] rd_data_f;
    logic [3:0] count_f;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    distributed_fifo_m #(.WORD_WIDTH(8), .ADDR_WIDTH(3), .MODE("STD")) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_s), .almost_full(af_s), .overflow(ovf_s),
        .rd_en(rd_en), .rd_data(rd_data_s), .empty(empty_s),
        .almost_empty(ae_s), .underflow(unf_s), .count(count_s)
    );

    distributed_fifo_m #(.WORD_WIDTH(8), .ADDR_WIDTH(3), .MODE("FWFT")) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_f), .almost_full(af_f), .overflow(ovf_f),
        .rd_en(rd_en), .rd_data(rd_data_f), .empty(empty_f),
        .almost_empty(ae_f), .underflow(unf_f), .count(count_f)
    );

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle();
        step(); step();
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({empty_s, ae_s, full_s, af_s, ovf_s, unf_s, count_s} !== {6'b110000, 4'd0}) begin
            n_bad++;
            $display("FAIL reset_flags_std: got %b, want %b", {empty_s, ae_s, full_s, af_s, ovf_s, unf_s, count_s}, {6'b110000, 4'd0});
        end
        n_cmp++;
        if ({empty_f, ae_f, full_f, af_f, ovf_f, unf_f, count_f} !== {6'b110000, 4'd0}) begin
            n_bad++;
            $display("FAIL reset_flags_fwft: got %b, want %b", {empty_f, ae_f, full_f, af_f, ovf_f, unf_f, count_f}, {6'b110000, 4'd0});
        end
        n_cmp++;
        if (rd_data_s !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_rd_data: got %h, want 00", rd_data_s);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'((i + 1) * 8'h11);
            step();
            n_cmp++;
            if ({count_s, full_s, af_s, ae_s, empty_s} !== {4'(i + 1), (i == 7), (i >= 6), (i == 0), 1'b0}) begin
                n_bad++;
                $display("FAIL fill_%0d: got cnt=%0d f=%b af=%b ae=%b e=%b, want cnt=%0d f=%b af=%b ae=%b e=0",
                         i, count_s, full_s, af_s, ae_s, empty_s, i + 1, (i == 7), (i >= 6), (i == 0));
            end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = 8'((i + 1) * 8'h11);
            n_cmp++;
            if (rd_data_f !== exp) begin
                n_bad++;
                $display("FAIL drain_fwft_head_%0d: got %h, want %h", i, rd_data_f, exp);
            end
            rd_en = 1'b1;
            step();
            n_cmp++;
            if (rd_data_s !== exp || count_s !== 4'(7 - i)) begin
                n_bad++;
                $display("FAIL drain_std_%0d: got data=%h cnt=%0d, want data=%h cnt=%0d", i, rd_data_s, count_s, exp, 7 - i);
            end
        end
        rd_en = 1'b0;
        n_cmp++;
        if ({empty_s, empty_f, full_s} !== 3'b110) begin
            n_bad++;
            $display("FAIL drain_empty: got %b, want 110", {empty_s, empty_f, full_s});
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(i + 1);
            step();
        end
        wr_data = 8'hFF;
        step();
        n_cmp++;
        if ({ovf_s, ovf_f, count_s, full_s} !== {2'b11, 4'd8, 1'b1}) begin
            n_bad++;
            $display("FAIL overflow_pulse: got ovf=%b%b cnt=%0d full=%b, want ovf=11 cnt=8 full=1", ovf_s, ovf_f, count_s, full_s);
        end
        wr_en = 1'b0;
        step();
        n_cmp++;
        if ({ovf_s, ovf_f} !== 2'b00) begin
            n_bad++;
            $display("FAIL overflow_one_cycle: got %b, want 00", {ovf_s, ovf_f});
        end
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hFF;
        step();
        n_cmp++;
        if ({rd_data_s, count_s, ovf_s} !== {8'h01, 4'd7, 1'b1}) begin
            n_bad++;
            $display("FAIL full_rdwr: got data=%h cnt=%0d ovf=%b, want data=01 cnt=7 ovf=1", rd_data_s, count_s, ovf_s);
        end
        wr_en = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            step();
            n_cmp++;
            if (rd_data_s !== 8'(i)) begin
                n_bad++;
                $display("FAIL overflow_drain_%0d: got %h, want %h", i, rd_data_s, 8'(i));
            end
        end
        rd_en = 1'b0;
        step();
        n_cmp++;
        if ({empty_s, count_s} !== {1'b1, 4'd0}) begin
            n_bad++;
            $display("FAIL overflow_no_ff: got e=%b cnt=%0d, want e=1 cnt=0", empty_s, count_s);
        end
    endtask

    task automatic test_underflow();
        idle(); rd_en = 1'b1;
        step();
        n_cmp++;
        if ({unf_s, unf_f, count_s} !== {2'b11, 4'd0}) begin
            n_bad++;
            $display("FAIL underflow_pulse: got unf=%b%b cnt=%0d, want unf=11 cnt=0", unf_s, unf_f, count_s);
        end
        rd_en = 1'b0;
        step();
        n_cmp++;
        if ({unf_s, unf_f} !== 2'b00) begin
            n_bad++;
            $display("FAIL underflow_one_cycle: got %b, want 00", {unf_s, unf_f});
        end
        rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'h5A;
        step();
        n_cmp++;
        if ({count_s, unf_s, empty_s} !== {4'd1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL empty_rdwr: got cnt=%0d unf=%b e=%b, want cnt=1 unf=1 e=0", count_s, unf_s, empty_s);
        end
        idle();
        n_cmp++;
        if (rd_data_f !== 8'h5A) begin
            n_bad++;
            $display("FAIL empty_rdwr_fwft: got %h, want 5a", rd_data_f);
        end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        n_cmp++;
        if ({rd_data_s, count_s} !== {8'h5A, 4'd0}) begin
            n_bad++;
            $display("FAIL empty_rdwr_read: got data=%h cnt=%0d, want data=5a cnt=0", rd_data_s, count_s);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] head;
        idle(); wr_en = 1'b1; wr_data = 8'hA1;
        step();
        wr_en = 1'b0;
        n_cmp++;
        if ({rd_data_f, empty_f} !== {8'hA1, 1'b0}) begin
            n_bad++;
            $display("FAIL fwft_first_word: got data=%h e=%b, want data=a1 e=0", rd_data_f, empty_f);
        end
        for (int i = 0; i < 20; i++) begin
            head = (i == 0) ? 8'hA1 : 8'(8'hB0 + i - 1);
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'hB0 + i);
            n_cmp++;
            if (rd_data_f !== head) begin
                n_bad++;
                $display("FAIL b2b_fwft_%0d: got %h, want %h", i, rd_data_f, head);
            end
            step();
            n_cmp++;
            if ({rd_data_s, count_s, count_f} !== {head, 4'd1, 4'd1}) begin
                n_bad++;
                $display("FAIL b2b_std_%0d: got data=%h cnt=%0d/%0d, want data=%h cnt=1/1", i, rd_data_s, count_s, count_f, head);
            end
        end
        wr_en = 1'b0;
        step();
        rd_en = 1'b0;
        n_cmp++;
        if ({rd_data_s, empty_s} !== {8'hC3, 1'b1}) begin
            n_bad++;
            $display("FAIL b2b_last: got data=%h e=%b, want data=c3 e=1", rd_data_s, empty_s);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            step();
        end
        rd_en = 1'b1; wr_en = 1'b0;
        step();
        // inputs held active during reset must be ignored
        rst_n = 1'b0; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
        step();
        n_cmp++;
        if ({empty_s, ae_s, full_s, af_s, ovf_s, unf_s, count_s, rd_data_s} !== {6'b110000, 4'd0, 8'h00}) begin
            n_bad++;
            $display("FAIL midreset_state: got %b, want %b", {empty_s, ae_s, full_s, af_s, ovf_s, unf_s, count_s, rd_data_s}, {6'b110000, 4'd0, 8'h00});
        end
        rst_n = 1'b1; idle();
        step();
        n_cmp++;
        if ({empty_f, count_f} !== {1'b1, 4'd0}) begin
            n_bad++;
            $display("FAIL midreset_ignored: got e=%b cnt=%0d, want e=1 cnt=0", empty_f, count_f);
        end
        wr_en = 1'b1; wr_data = 8'h33;
        step();
        wr_en = 1'b0;
        n_cmp++;
        if (rd_data_f !== 8'h33) begin
            n_bad++;
            $display("FAIL midreset_fwft: got %h, want 33", rd_data_f);
        end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        n_cmp++;
        if ({rd_data_s, empty_s} !== {8'h33, 1'b1}) begin
            n_bad++;
            $display("FAIL midreset_std: got data=%h e=%b, want data=33 e=1", rd_data_s, empty_s);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/distributed_fifo_m.md
# distributed_fifo_m

Synchronous single-clock FIFO built on LUT (distributed) RAM, parametrised in word width and depth, with standard (registered read) or first-word-fall-through output mode. It provides full/empty, programmable almost-full/almost-empty, an occupancy count and overflow/underflow pulses. It is the general buffering element for shallow, wide queues between pipeline stages, where block RAM is wasteful.

## Interface
- `WORD_WIDTH`, no default: data word width in bits, ≥1.
- `ADDR_WIDTH`, no default: log2 of depth; `DEPTH = 2**ADDR_WIDTH`, ≥1.
- `MODE`, default "STD": "STD" gives registered `rd_data`; "FWFT" gives head word visible on `rd_data` whenever `!empty`.
- `ALMOST_FULL_THR`, default `DEPTH-1`: `almost_full` when count ≥ threshold.
- `ALMOST_EMPTY_THR`, default 1: `almost_empty` when count ≤ threshold.
- `clk  in  1`  single clock, all logic on posedge.
- `rst_n  in  1`  reset, synchronous, active-low.
- `wr_en  in  1`  write request.
- `wr_data  in  WORD_WIDTH`  write word.
- `full  out  1`  count == DEPTH.
- `almost_full  out  1`  count ≥ ALMOST_FULL_THR.
- `overflow  out  1`  one-cycle pulse: `wr_en` seen while full.
- `rd_en  in  1`  read request / pop.
- `rd_data  out  WORD_WIDTH`  read word.
- `empty  out  1`  count == 0.
- `almost_empty  out  1`  count ≤ ALMOST_EMPTY_THR.
- `underflow  out  1`  one-cycle pulse: `rd_en` seen while empty.
- `count  out  ADDR_WIDTH+1`  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH×WORD_WIDTH distributed RAM; write pointer and read pointer, each ADDR_WIDTH bits, wrap naturally modulo DEPTH; no reset of RAM contents.
- Write accept = `wr_en & !full`. On accept, the word is stored at `wr_ptr` and `wr_ptr` increments.
- Read accept = `rd_en & !empty`. On accept, `rd_ptr` increments.
- Accept decisions use pre-edge flags only. When full with simultaneous rd+wr, the read is accepted and the write is dropped with `overflow`. When empty with simultaneous rd+wr, the write is accepted and the read is dropped with `underflow`.
- `count` next value: +1 on write-only accept, −1 on read-only accept, unchanged on both or neither.
- `full`, `empty`, `almost_*` are decoded from the registered `count`.
- STD mode: on read accept, `rd_data` ← `ram[rd_ptr]` at that edge. `rd_data` holds otherwise, including when empty.
- FWFT mode: `rd_data = ram[rd_ptr]`, combinational from the async read port. It is undefined while `empty`. `rd_en` acts as acknowledge/pop.
- Reset (`rst_n`=0 at an edge), which also applies mid-operation: pointers and count go to 0, `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0 (unless ALMOST_FULL_THR=0), overflow/underflow=0, STD `rd_data`=0. Inputs are ignored during reset cycles, and stored data is discarded.

## Timing
- Write at edge k: from edge k, count/empty reflect it. In FWFT, the word is on `rd_data` in the cycle after edge k, giving 1-cycle write-to-read latency.
- STD read: `rd_en` in cycle before edge k gives data valid after edge k, a latency of 1.
- FWFT read: data is valid in the same cycle as `rd_en`, and the next word appears after the edge.
- Sustained simultaneous read and write: 1 word/cycle each, with count constant.
- Flags are registered-count decodes; there is no combinational path from `wr_en`/`rd_en` to any flag.
- Overflow/underflow pulse in the cycle after the offending edge, for exactly one cycle per offending cycle.

## Structure
- Shared package `mem_pkg`: mode string constants "STD"/"FWFT"; function `cnt_width(addr_width)` returning addr_width+1. The package is reused by later memory blocks.
- Sub-module: `sdp_distributed_ram_m` with `OUT_REGISTERED="NO"` as storage.
- The STD output register lives in `distributed_fifo_m`, because it is gated by read accept and reset.
- Elaboration check: thresholds must lie within 0..DEPTH, and MODE must be one of the two constants; otherwise `$error`.

## Test plan
Configuration for all scenarios: WORD_WIDTH=8, ADDR_WIDTH=3 (DEPTH 8).
- Reset, then idle: empty=1, almost_empty=1, full=0, count=0, STD rd_data=0x00.
- STD, write 0x11..0x88 (8 cycles), then read 8: full=1 after 8th write, almost_full at count 7. rd_data = 0x11..0x88, each 1 cycle after `rd_en`. empty=1 after the last read.
- Full, assert wr_en=1 with 0xFF: overflow pulse, count stays 8, 0xFF is never read. Full with simultaneous rd+wr: read returns the head word, count becomes 7, overflow=1.
- Empty, assert rd_en: underflow pulse, count stays 0. Empty with simultaneous rd+wr 0x5A: count becomes 1, underflow=1, next read returns 0x5A.
- FWFT, write 0xA1: rd_data=0xA1 and empty=0 the next cycle. Continuous rd+wr for 20 cycles with an incrementing pattern: order is preserved across pointer wrap, count constant.
- Fill to count 5, assert rst_n=0 for one cycle: all outputs at reset values. Write 0x33 then read: returns 0x33, with no stale data.
